// File: rtl/dmem_responder_pkg.sv
// Shared CPU constants: funct3 encodings for loads/stores, decoder opcodes,
// byte-enable width and the store-buffer state type.
package dmem_responder_pkg;

   // Load/store funct3 encodings
   localparam logic [2:0] Funct3B  = 3'b000;
   localparam logic [2:0] Funct3H  = 3'b001;
   localparam logic [2:0] Funct3W  = 3'b010;
   localparam logic [2:0] Funct3Bu = 3'b100;
   localparam logic [2:0] Funct3Hu = 3'b101;

   // Decoder opcodes for the memory instruction classes
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;

   localparam int unsigned BeW   = 4;
   localparam int unsigned WordW = 32;

   typedef logic [BeW-1:0]   be_t;
   typedef logic [WordW-1:0] word_t;

   typedef enum logic {
      StEmpty,
      StHeld
   } buf_state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and legality (funct3 plus alignment) for one access.
module dmem_lane_unit
   import dmem_responder_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic [1:0] i_lane,
   input  word_t      i_wdata,
   input  word_t      i_word,
   output be_t        o_be,
   output word_t      o_wdata_rep,
   output word_t      o_rdata,
   output logic       o_ld_legal,
   output logic       o_st_legal
);

   word_t w_shift;
   logic  w_size_ok;
   logic  w_ld_code;
   logic  w_st_code;

   always_comb begin
      o_be        = '0;
      o_wdata_rep = i_wdata;
      o_rdata     = '0;
      w_size_ok   = 1'b0;
      w_ld_code   = 1'b0;
      w_st_code   = 1'b0;
      w_shift     = i_word >> {i_lane, 3'b000};
      case (i_funct3)
         Funct3B, Funct3Bu: begin
            w_size_ok   = 1'b1;
            w_ld_code   = 1'b1;
            w_st_code   = (i_funct3 == Funct3B);
            o_be        = 4'b0001 << i_lane;
            o_wdata_rep = {4{i_wdata[7:0]}};
            o_rdata     = {24'b0, w_shift[7:0]};
         end
         Funct3H, Funct3Hu: begin
            w_size_ok   = ~i_lane[0];
            w_ld_code   = 1'b1;
            w_st_code   = (i_funct3 == Funct3H);
            o_be        = 4'b0011 << i_lane;
            o_wdata_rep = {2{i_wdata[15:0]}};
            o_rdata     = {16'b0, w_shift[15:0]};
         end
         Funct3W: begin
            w_size_ok   = (i_lane == 2'b00);
            w_ld_code   = 1'b1;
            w_st_code   = 1'b1;
            o_be        = 4'b1111;
            o_rdata     = i_word;
         end
         default: ;
      endcase
   end

   assign o_ld_legal = w_ld_code & w_size_ok;
   assign o_st_legal = w_st_code & w_size_ok;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: async-read array fronted by a one-entry store buffer
// with load forwarding, sticky error flag and load/store counters.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_readM,
   input  logic        mem_writeM,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  functM,
   output logic [31:0] read_data,
   output logic        err,
   output logic [15:0] ld_cnt,
   output logic [15:0] st_cnt
);

   word_t             r_mem [2**ADDR_W];
   buf_state_e        r_state;
   buf_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_buf_idx;
   be_t               r_buf_be;
   word_t             r_buf_data;
   logic              r_err;
   logic [15:0]       r_ld_cnt;
   logic [15:0]       r_st_cnt;

   logic [ADDR_W-1:0] w_idx;
   logic              w_fwd;
   word_t             w_word;
   be_t               w_be;
   word_t             w_wrep;
   word_t             w_rdata;
   logic              w_ld_legal;
   logic              w_st_legal;
   logic              w_ld_ok;
   logic              w_st_ok;
   logic              w_err_ev;
   logic              w_unused_addr;

   assign w_idx         = addr[ADDR_W+1:2];
   assign w_unused_addr = ^addr[31:ADDR_W+2];

   // A pending entry is dropped by reset, so it must not be forwarded then either.
   assign w_fwd = (r_state == StHeld) && !rst && (r_buf_idx == w_idx);

   always_comb begin
      w_word = r_mem[w_idx];
      for (int b = 0; b < BeW; b++) begin
         if (w_fwd && r_buf_be[b]) w_word[8*b +: 8] = r_buf_data[8*b +: 8];
      end
   end

   dmem_lane_unit u_lane (
      .i_funct3    (functM),
      .i_lane      (addr[1:0]),
      .i_wdata     (wdata),
      .i_word      (w_word),
      .o_be        (w_be),
      .o_wdata_rep (w_wrep),
      .o_rdata     (w_rdata),
      .o_ld_legal  (w_ld_legal),
      .o_st_legal  (w_st_legal)
   );

   // A simultaneous read+write lets the store through but kills the load.
   assign w_ld_ok   = mem_readM & ~mem_writeM & w_ld_legal;
   assign w_st_ok   = mem_writeM & w_st_legal;
   assign w_err_ev  = (mem_readM & ~w_ld_ok) | (mem_writeM & ~w_st_ok);
   assign read_data = w_ld_ok ? w_rdata : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StEmpty: if (w_st_ok) w_state_nxt = StHeld;
         StHeld:  w_state_nxt = w_st_ok ? StHeld : StEmpty;
         default: w_state_nxt = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= StEmpty;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_st_ok) begin
         r_buf_idx  <= w_idx;
         r_buf_be   <= w_be;
         r_buf_data <= w_wrep;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == StHeld && !rst) begin
         for (int b = 0; b < BeW; b++) begin
            if (r_buf_be[b]) r_mem[r_buf_idx][8*b +: 8] <= r_buf_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err    <= 1'b0;
         r_ld_cnt <= '0;
         r_st_cnt <= '0;
      end else begin
         if (w_err_ev) r_err    <= 1'b1;
         if (w_ld_ok)  r_ld_cnt <= r_ld_cnt + 16'd1;
         if (w_st_ok)  r_st_cnt <= r_st_cnt + 16'd1;
      end
   end

   assign err    = r_err;
   assign ld_cnt = r_ld_cnt;
   assign st_cnt = r_st_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: forwarding, sub-word access, errors,
// reset behaviour, aliasing and counter wrap.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_readM;
   logic        mem_writeM;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  functM;
   logic [31:0] read_data;
   logic        err;
   logic [15:0] ld_cnt;
   logic [15:0] st_cnt;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

   dmem_responder #(.ADDR_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_readM  (mem_readM),
      .mem_writeM (mem_writeM),
      .addr       (addr),
      .wdata      (wdata),
      .functM     (functM),
      .read_data  (read_data),
      .err        (err),
      .ld_cnt     (ld_cnt),
      .st_cnt     (st_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_readM  = 1'b0;
      mem_writeM = 1'b0;
      addr       = '0;
      wdata      = '0;
      functM     = FW;
   endtask

   // Drive one access for a cycle; optionally check read_data mid-cycle.
   task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic chk, input logic [31:0] exp, input string tag);
      mem_readM  = rd;
      mem_writeM = wr;
      addr       = a;
      wdata      = d;
      functM     = f;
      @(negedge clk);
      if (chk) check_val(tag, read_data, exp);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic e, input logic [15:0] l,
                             input logic [15:0] s);
      check_val({tag, ".err"}, {31'b0, err}, {31'b0, e});
      check_val({tag, ".ld_cnt"}, {16'b0, ld_cnt}, {16'b0, l});
      check_val({tag, ".st_cnt"}, {16'b0, st_cnt}, {16'b0, s});
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_regs("reset", 1'b0, 16'd0, 16'd0);
      @(negedge clk);
      check_val("idle_rdata", read_data, 32'h0);
      @(posedge clk);
      #1;

      // Store then immediate load: forwarded, later from the array
      do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, FW, 1'b0, 32'h0, "sw10");
      do_op(1'b1, 1'b0, 32'h10, 32'h0, FW, 1'b1, 32'hDEADBEEF, "lw10_fwd");
      idle_cycle();
      idle_cycle();
      do_op(1'b1, 1'b0, 32'h10, 32'h0, FW, 1'b1, 32'hDEADBEEF, "lw10_arr");
      check_regs("after_sw", 1'b0, 16'd2, 16'd1);

      // Sub-word store with forwarded sub-word loads
      do_op(1'b0, 1'b1, 32'h11, 32'h00000055, FB, 1'b0, 32'h0, "sb11");
      do_op(1'b1, 1'b0, 32'h11, 32'h0, FBU, 1'b1, 32'h00000055, "lbu11");
      do_op(1'b1, 1'b0, 32'h10, 32'h0, FHU, 1'b1, 32'h000055EF, "lhu10");
      do_op(1'b1, 1'b0, 32'h10, 32'h0, FW, 1'b1, 32'hDEAD55EF, "lw10_merged");
      do_op(1'b1, 1'b0, 32'h13, 32'h0, FB, 1'b1, 32'h000000DE, "lb13_zext");
      do_op(1'b1, 1'b0, 32'h12, 32'h0, FH, 1'b1, 32'h0000DEAD, "lh12_zext");

      // Back-to-back stores, same word twice
      do_op(1'b0, 1'b1, 32'h20, 32'h1, FW, 1'b0, 32'h0, "sw20a");
      do_op(1'b0, 1'b1, 32'h24, 32'h2, FW, 1'b0, 32'h0, "sw24");
      do_op(1'b0, 1'b1, 32'h20, 32'h3, FW, 1'b0, 32'h0, "sw20b");
      do_op(1'b1, 1'b0, 32'h20, 32'h0, FW, 1'b1, 32'h3, "lw20");
      do_op(1'b1, 1'b0, 32'h24, 32'h0, FW, 1'b1, 32'h2, "lw24");
      check_regs("b2b", 1'b0, 16'd9, 16'd5);

      // Misaligned load and store
      do_op(1'b1, 1'b0, 32'h13, 32'h0, FW, 1'b1, 32'h0, "lw13_mis");
      check_regs("mis_lw", 1'b1, 16'd9, 16'd5);
      do_op(1'b0, 1'b1, 32'h21, 32'hFFFF, FH, 1'b0, 32'h0, "sh21_mis");
      do_op(1'b1, 1'b0, 32'h20, 32'h0, FW, 1'b1, 32'h3, "lw20_unchanged");
      check_regs("mis_sh", 1'b1, 16'd10, 16'd5);

      // Pending store discarded by reset; load during reset reads the array
      do_op(1'b0, 1'b1, 32'h30, 32'h11112222, FW, 1'b0, 32'h0, "sw30_prior");
      idle_cycle();
      do_op(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, FW, 1'b0, 32'h0, "sw30_rst");
      rst = 1'b1;
      do_op(1'b1, 1'b0, 32'h30, 32'h0, FW, 1'b1, 32'h11112222, "lw30_in_rst");
      rst = 1'b0;
      check_regs("rst", 1'b0, 16'd0, 16'd0);
      do_op(1'b1, 1'b0, 32'h30, 32'h0, FW, 1'b1, 32'h11112222, "lw30_after");

      // Aliasing above ADDR_W+1
      do_op(1'b1, 1'b0, 32'h1010, 32'h0, FW, 1'b1, 32'hDEAD55EF, "lw1010_alias");
      do_op(1'b0, 1'b1, 32'hFFFF_F044, 32'h12345678, FW, 1'b0, 32'h0, "sw_hi44");
      idle_cycle();
      do_op(1'b1, 1'b0, 32'h44, 32'h0, FW, 1'b1, 32'h12345678, "lw44_alias");
      check_regs("alias", 1'b0, 16'd3, 16'd1);

      // Read and write together: store proceeds, load dropped
      do_op(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, FW, 1'b1, 32'h0, "rw40");
      check_regs("rw", 1'b1, 16'd3, 16'd2);
      do_op(1'b1, 1'b0, 32'h40, 32'h0, FW, 1'b1, 32'hCAFEF00D, "lw40");

      // Illegal funct3 on load, then BU on a store
      do_reset();
      do_op(1'b1, 1'b0, 32'h40, 32'h0, 3'b011, 1'b1, 32'h0, "ld_f011");
      check_regs("ill_ld", 1'b1, 16'd0, 16'd0);
      do_reset();
      do_op(1'b0, 1'b1, 32'h40, 32'hFF, FBU, 1'b0, 32'h0, "st_fbu");
      check_regs("ill_st", 1'b1, 16'd0, 16'd0);
      do_op(1'b1, 1'b0, 32'h40, 32'h0, FW, 1'b1, 32'hCAFEF00D, "lw40_unchanged");

      // Load counter wrap
      do_reset();
      mem_readM = 1'b1;
      addr      = 32'h10;
      functM    = FW;
      repeat (65535) @(posedge clk);
      #1;
      check_val("ld_cnt_ffff", {16'b0, ld_cnt}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      check_val("ld_cnt_wrap", {16'b0, ld_cnt}, 32'h0);
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
